// File: rtl/shift_unit_arbiter.sv
// rtl/shift_unit_arbiter.sv - two-requester round-robin arbiter for a shared 16-bit shifter
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   req0_valid/ready/a/b/op         requester 0 (op: 00 SRA, 01 SRL, 10 SLL, 11 pass)
//   req1_valid/ready/a/b/op         requester 1, same encoding
//   rsp_valid/ready                 response handshake from the one-entry result buffer
//   rsp_id, rsp_y, rsp_overflow     issuing requester, shifted result, A[15]^Y[15]
module shift_unit_arbiter #(
  parameter int DATA_W  = 16,
  parameter int SHAMT_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [1:0]        req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [1:0]        req1_op,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_overflow
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t              state, state_nxt;
  logic                ptr, ptr_nxt;      // 0 favours requester 0 on a tie
  logic                grant0, grant1;
  logic                can_accept;
  logic                accept;
  logic [DATA_W-1:0]   sel_a, sel_b;
  logic [1:0]          sel_op;
  logic [SHAMT_W-1:0]  shamt;
  logic [DATA_W-1:0]   y;

  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    can_accept = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    accept     = 1'b0;
    sel_a      = req0_a;
    sel_b      = req0_b;
    sel_op     = req0_op;
    shamt      = '0;
    y          = '0;
    state_nxt  = state;
    ptr_nxt    = ptr;

    grant0 = req0_valid & (~req1_valid | ~ptr);
    grant1 = req1_valid & (~req0_valid |  ptr);

    // A draining buffer frees its slot in the same cycle, giving 1 op/cycle.
    can_accept = (state == EMPTY) | rsp_ready;

    // Readies are suppressed during reset so nothing is handed over then.
    req0_ready = grant0 & can_accept & rst_n;
    req1_ready = grant1 & can_accept & rst_n;
    accept     = req0_ready | req1_ready;

    if (req1_ready) begin
      sel_a  = req1_a;
      sel_b  = req1_b;
      sel_op = req1_op;
    end

    shamt = sel_b[SHAMT_W-1:0];
    case (sel_op)
      2'b00:   y = $unsigned($signed(sel_a) >>> shamt);
      2'b01:   y = sel_a >> shamt;
      2'b10:   y = sel_a << shamt;
      default: y = sel_a;
    endcase

    if (accept) begin
      state_nxt = FULL;
    end else if (rsp_ready) begin
      state_nxt = EMPTY;
    end

    // Pointer hands priority to the requester that was not just served.
    if (req0_ready) begin
      ptr_nxt = 1'b1;
    end else if (req1_ready) begin
      ptr_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= EMPTY;
      ptr          <= 1'b0;
      rsp_y        <= '0;
      rsp_id       <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (accept) begin
        rsp_y        <= y;
        rsp_id       <= req1_ready;
        rsp_overflow <= sel_a[DATA_W-1] ^ y[DATA_W-1];
      end
    end
  end

  assign rsp_valid = (state == FULL);

endmodule

// File: doc/shift_unit_arbiter.md
Name: shift_unit_arbiter

Overview:
- Shares a single 16-bit shift datapath between two requesters.
- Supported ops: arithmetic right, logical right and logical left shift.
- Round-robin arbitration, valid/ready handshakes on both sides, one-entry registered result buffer.
- Sits between the issue logic and the shared ALU shift resource; returns a result tagged with the requester ID plus the sign-change overflow flag.

Parameters:
- DATA_W, 16, operand/result width; only 16 is supported.
- SHAMT_W, 4, shift-amount bits taken from B[SHAMT_W-1:0]; the upper bits of B are ignored.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  16  requester 0 operand A.
- req0_b  in  16  requester 0 shift amount (B[3:0] used).
- req0_op  in  2  requester 0 op: 00 SRA, 01 SRL, 10 SLL, 11 pass-through.
- req1_valid / req1_ready / req1_a / req1_b / req1_op  same as requester 0, for requester 1.
- rsp_valid  out  1  result buffer holds a result.
- rsp_ready  in  1  consumer takes the result.
- rsp_id  out  1  requester that issued the result.
- rsp_y  out  16  shifted result.
- rsp_overflow  out  1  A[15] != Y[15].

Behaviour:
- Clock/reset: single clock clk; synchronous active-low reset rst_n, sampled on the rising edge.
- Reset values:
  - rsp_valid=0, rsp_y=0, rsp_overflow=0, rsp_id=0.
  - Priority pointer favours requester 0.
  - req*_ready=0 while rst_n=0.
- Reset mid-operation: any held result is discarded; no response is produced for it.
- Buffer state machine, two states:
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
  - EMPTY->FULL on accept.
  - FULL->EMPTY on rsp_ready with no new accept.
  - FULL->FULL on a drain and accept in the same cycle.
- can_accept = EMPTY or (FULL and rsp_ready). Throughput is 1 op/cycle with rsp_ready held high.
- Grant (combinational):
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the requester named by the pointer.
  - reqN_ready = grantN and can_accept. At most one ready is high per cycle.
- Pointer: after an accepted transfer from requester N, the pointer moves to the other requester. It is unchanged when nothing is accepted.
- Latency: an op accepted at edge k has rsp_valid=1 with its result after edge k. Results are computed from operands sampled at acceptance.
- Requester rules:
  - Requester N must hold valid, a, b and op stable until readyN.
  - The arbiter never accepts without valid.
  - A requester that drops valid before ready loses its slot; no state change.
- Response rules: while rsp_valid=1 and rsp_ready=0, rsp_y, rsp_overflow and rsp_id are held stable.
- Shift semantics, s = b[3:0] (0..15):
  - SRA: fill with A[15].
  - SRL: fill with 0.
  - SLL: shift left, fill with 0.
  - op 11: Y=A.
  - s=0 gives Y=A for every op.
- Overflow: rsp_overflow = A[15] XOR Y[15] for all ops, registered with Y. It is therefore 0 for SRA and pass-through, and for any s=0.

Test Plan:
- req0 SRA a=0x8000 b=0x0004, rsp_ready=1 -> next cycle rsp_valid=1, rsp_y=0xF800, rsp_overflow=0, rsp_id=0; same op with b=0x000F -> rsp_y=0xFFFF.
- req1 SRL a=0x8000 b=0x0013 (upper B ignored, s=3) -> rsp_y=0x1000, rsp_overflow=1, rsp_id=1; req0 SLL a=0x4001 b=1 -> rsp_y=0x8002, rsp_overflow=1.
- Both valid continuously for 4 cycles after reset, rsp_ready=1 -> accepts in order id 0,1,0,1, one per cycle, with consecutive rsp_valid.
- Backpressure:
  - Accept one op, then hold rsp_ready=0 for 3 cycles with req0_valid=1.
  - Required: req0_ready=0 for those cycles and rsp_y/rsp_id stable.
  - On rsp_ready=1: req0_ready=1 the same cycle, and the new result appears next cycle.
- Reset mid-operation:
  - rsp_valid=1 and req1_valid=1, then rst_n=0 for one edge.
  - Required: after that edge rsp_valid=0, rsp_y=0, and no req ready during reset.
  - First grant after reset with both valid goes to id 0.
- Pass-through: op=11 a=0x8123 b=5 -> rsp_y=0x8123, rsp_overflow=0.
